// File: rtl/bus_slot_pkg.sv
// bus_slot_pkg: shared constants and types for the bus slot sequencer.
//   DEFAULT_PHASE_BITS : default slot length exponent (slot = 2^PHASE_BITS clocks)
//   chIndex_t          : generic channel index type (wide enough for any channel count)
//   CH_VIDEO / CH_CPU  : named channels of the classic two-master configuration
package bus_slot_pkg;

   localparam int DEFAULT_PHASE_BITS = 3;
   localparam int MAX_CH_W           = 8;

   typedef logic [MAX_CH_W-1:0] chIndex_t;

   localparam chIndex_t CH_VIDEO = chIndex_t'(0);
   localparam chIndex_t CH_CPU   = chIndex_t'(1);

endpackage

// File: rtl/bus_slot_arbiter.sv
// bus_slot_arbiter: combinational grant decision for the slot about to start.
//   nextSlot    in  CH_W    index of the upcoming slot (its nominal owner)
//   req         in  NUM_CH  per-channel bus request
//   donateEn    in  1       allows an idle owner's slot to go to DONATE_CH
//   nextGrant   out NUM_CH  one-hot owner of the upcoming slot
//   nextDonated out 1       upcoming slot is donated to DONATE_CH
module bus_slot_arbiter
   import bus_slot_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DONATE_CH = NUM_CH - 1,
   localparam int CH_W     = $clog2(NUM_CH)
) (
   input  logic [CH_W-1:0]   nextSlot,
   input  logic [NUM_CH-1:0] req,
   input  logic              donateEn,
   output logic [NUM_CH-1:0] nextGrant,
   output logic              nextDonated
);

   localparam logic [CH_W-1:0] DONATE_IDX = CH_W'(DONATE_CH);

   // A requesting owner always keeps its slot; an idle owner only loses it
   // when the donation target actually wants the bus.
   always_comb begin
      nextDonated = donateEn && !req[nextSlot] && (nextSlot != DONATE_IDX) && req[DONATE_CH];
      nextGrant   = nextDonated ? NUM_CH'(1) << DONATE_CH : NUM_CH'(1) << nextSlot;
   end

endmodule

// File: rtl/bus_slot_sequencer.sv
// bus_slot_sequencer: round-robin slot sequencer for the shared memory bus.
//   clk          in  1           master clock
//   reset_n      in  1           asynchronous active-low reset
//   req          in  NUM_CH      per-channel bus request (level)
//   donate_en    in  1           enables donation of idle slots to DONATE_CH
//   stall        in  1           wait state; holds the last phase of the slot
//   bus_phase    out PHASE_BITS  phase within the current slot
//   slot         out CH_W        index of the current slot (nominal owner)
//   grant        out NUM_CH      one-hot bus owner for the current slot
//   donated      out 1           current slot was donated to DONATE_CH
//   slot_start   out 1           first phase of a slot
//   cycle_ready  out 1           last phase of a slot and not stalled
//   clk8_en_p    out 1           CPU clock enable, odd phases
//   clk8_en_n    out 1           CPU clock enable, even phases
module bus_slot_sequencer
   import bus_slot_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int PHASE_BITS = DEFAULT_PHASE_BITS,
   parameter int DONATE_CH  = NUM_CH - 1,
   localparam int CH_W      = $clog2(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_CH-1:0]     req,
   input  logic                  donate_en,
   input  logic                  stall,
   output logic [PHASE_BITS-1:0] bus_phase,
   output logic [CH_W-1:0]       slot,
   output logic [NUM_CH-1:0]     grant,
   output logic                  donated,
   output logic                  slot_start,
   output logic                  cycle_ready,
   output logic                  clk8_en_p,
   output logic                  clk8_en_n
);

   localparam logic [PHASE_BITS-1:0] LAST      = '1;
   localparam logic [CH_W-1:0]       LAST_SLOT = CH_W'(NUM_CH - 1);

   logic              atLast;
   logic              advance;
   logic [CH_W-1:0]   nextSlot;
   logic [NUM_CH-1:0] nextGrant;
   logic              nextDonated;

   // Explicit wrap keeps non-power-of-2 channel counts off unused indices.
   always_comb begin
      atLast   = bus_phase == LAST;
      advance  = atLast && !stall;
      nextSlot = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
   end

   bus_slot_arbiter #(
      .NUM_CH    (NUM_CH),
      .DONATE_CH (DONATE_CH)
   ) arbiter (
      .nextSlot    (nextSlot),
      .req         (req),
      .donateEn    (donate_en),
      .nextGrant   (nextGrant),
      .nextDonated (nextDonated)
   );

   // Phase wraps naturally at LAST; a stall only freezes it there. Grant and
   // slot are captured only at the advance so they stay put for the whole slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_phase <= '0;
         slot      <= CH_W'(CH_VIDEO);
         grant     <= NUM_CH'(1) << CH_VIDEO;
         donated   <= 1'b0;
      end else begin
         if (!(atLast && stall))
            bus_phase <= bus_phase + 1'b1;
         if (advance) begin
            slot    <= nextSlot;
            grant   <= nextGrant;
            donated <= nextDonated;
         end
      end
   end

   assign slot_start  = bus_phase == '0;
   assign cycle_ready = advance;
   assign clk8_en_p   = bus_phase[0];
   assign clk8_en_n   = !bus_phase[0];

endmodule

// File: tb/tb_bus_slot_sequencer.sv
// tb_bus_slot_sequencer: randomized model-checked bench for two sequencer
// configurations (2 channels x 8 clocks, 3 channels x 4 clocks) plus
// hand-computed directed expectations.
module tb_bus_slot_sequencer;
   import bus_slot_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [1:0] req0 = '0;
   logic [2:0] req1 = '0;
   logic don0 = 1'b0, don1 = 1'b0, stall0 = 1'b0, stall1 = 1'b0;

   logic [2:0] ph0; logic s0; logic [1:0] g0; logic d0, ss0, cr0, p0, n0;
   logic [1:0] ph1; logic [1:0] s1; logic [2:0] g1; logic d1, ss1, cr1, p1, n1;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int crq[$];

   int mPhase[2];
   int mSlot[2];
   int mOwner[2];
   bit mDon[2];

   always #5 clk = ~clk;

   bus_slot_sequencer #(.NUM_CH(2), .PHASE_BITS(3), .DONATE_CH(int'(CH_CPU))) dut0 (
      .clk(clk), .reset_n(reset_n), .req(req0), .donate_en(don0), .stall(stall0),
      .bus_phase(ph0), .slot(s0), .grant(g0), .donated(d0), .slot_start(ss0),
      .cycle_ready(cr0), .clk8_en_p(p0), .clk8_en_n(n0));

   bus_slot_sequencer #(.NUM_CH(3), .PHASE_BITS(2)) dut1 (
      .clk(clk), .reset_n(reset_n), .req(req1), .donate_en(don1), .stall(stall1),
      .bus_phase(ph1), .slot(s1), .grant(g1), .donated(d1), .slot_start(ss1),
      .cycle_ready(cr1), .clk8_en_p(p1), .clk8_en_n(n1));

   function automatic int nch(int i); return i ? 3 : 2; endfunction
   function automatic int lastOf(int i); return i ? 3 : 7; endfunction
   function automatic int dch(int i); return i ? 2 : 1; endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Slot-level model: a slot is a run of clocks; it ends on its last phase
   // unless stalled, and the next owner is chosen from the inputs seen then.
   task automatic modelStep(int i, int rq, bit st, bit dn);
      int o;
      if (mPhase[i] < lastOf(i)) mPhase[i]++;
      else if (!st) begin
         mPhase[i] = 0;
         mSlot[i] = (mSlot[i] + 1) % nch(i);
         o = mSlot[i];
         if (dn && !rq[o] && o != dch(i) && rq[dch(i)]) begin
            mOwner[i] = dch(i);
            mDon[i] = 1'b1;
         end else begin
            mOwner[i] = o;
            mDon[i] = 1'b0;
         end
      end
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            mPhase[i] = 0; mSlot[i] = 0; mOwner[i] = 0; mDon[i] = 1'b0;
         end
      end else begin
         modelStep(0, int'(req0), stall0, don0);
         modelStep(1, int'(req1), stall1, don1);
      end
   end

   always @(negedge clk) begin
      chk("m0_phase", ph0, mPhase[0]);
      chk("m0_slot", s0, mSlot[0]);
      chk("m0_grant", g0, 1 << mOwner[0]);
      chk("m0_donated", d0, mDon[0]);
      chk("m0_slot_start", ss0, mPhase[0] == 0);
      chk("m0_cycle_ready", cr0, mPhase[0] == lastOf(0) && !stall0);
      chk("m0_clk8p", p0, mPhase[0] % 2);
      chk("m0_clk8n", n0, 1 - mPhase[0] % 2);
      chk("m1_phase", ph1, mPhase[1]);
      chk("m1_slot", s1, mSlot[1]);
      chk("m1_grant", g1, 1 << mOwner[1]);
      chk("m1_donated", d1, mDon[1]);
      chk("m1_slot_start", ss1, mPhase[1] == 0);
      chk("m1_cycle_ready", cr1, mPhase[1] == lastOf(1) && !stall1);
      chk("m1_clk8p", p1, mPhase[1] % 2);
      chk("m1_clk8n", n1, 1 - mPhase[1] % 2);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic runTo(int t);
      while (cyc < t) tick();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_phase", ph0, 0);
      chk("rst_grant", g0, 1);
      chk("rst_slot_start", ss0, 1);
      chk("rst_cycle_ready", cr0, 0);
      chk("rst_clk8p", p0, 0);
      chk("rst_clk8n", n0, 1);
      chk("rst_grant3", g1, 1);
      reset_n = 1'b1;
      cyc = 0;
      for (int c = 0; c <= 24; c++) begin
         if (c > 0) tick();
         if (cr0) crq.push_back(cyc);
         if (c % 8 == 0 && c < 24) chk($sformatf("idle_grant@%0d", c), g0, (c == 8) ? 2 : 1);
         if (c % 4 == 0 && c <= 12) begin
            chk($sformatf("ch3_grant@%0d", c), g1, (c == 4) ? 2 : (c == 8) ? 4 : 1);
            chk($sformatf("ch3_slot@%0d", c), s1, (c / 4) % 3);
         end
         chk("ch3_slot_range", s1 < 2'd3, 1);
         if (c == 1) chk("clk8p_odd", p0, 1);
         if (c == 2) chk("clk8p_even", p0, 0);
      end
      chk("cr_count", crq.size(), 3);
      if (crq.size() == 3) begin
         chk("cr_first", crq[0], 7);
         chk("cr_second", crq[1], 15);
         chk("cr_third", crq[2], 23);
      end
      don0 = 1'b1;
      req0 = 2'b10;
      runTo(32);
      chk("don_even_grant", g0, 2);
      chk("don_even_flag", d0, 1);
      runTo(40);
      chk("don_odd_grant", g0, 2);
      chk("don_odd_flag", d0, 0);
      runTo(52);
      chk("don_mid_grant", g0, 2);
      don0 = 1'b0;
      runTo(55);
      chk("don_drop_grant", g0, 2);
      chk("don_drop_flag", d0, 1);
      runTo(64);
      chk("don_off_grant", g0, 1);
      chk("don_off_flag", d0, 0);
      req0 = 2'b11;
      don0 = 1'b1;
      runTo(80);
      chk("owner_wins_grant", g0, 1);
      chk("owner_wins_flag", d0, 0);
      chk("owner_wins_slot", s0, 0);
      req0 = 2'b00;
      don0 = 1'b0;
      runTo(87);
      chk("stall_phase", ph0, 7);
      stall0 = 1'b1;
      #1;
      chk("stall_cr_low", cr0, 0);
      runTo(89);
      chk("stall_hold_phase", ph0, 7);
      chk("stall_hold_grant", g0, 1);
      chk("stall_hold_clk8p", p0, 1);
      chk("stall_hold_cr", cr0, 0);
      runTo(90);
      chk("stall_no_start", ss0, 0);
      stall0 = 1'b0;
      #1;
      chk("stall_release_cr", cr0, 1);
      runTo(91);
      chk("stall_next_phase", ph0, 0);
      chk("stall_next_grant", g0, 2);
      chk("stall_next_slot", s0, 1);
      runTo(95);
      chk("midrst_pre_phase", ph0, 4);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_phase", ph0, 0);
      chk("midrst_slot", s0, 0);
      chk("midrst_grant", g0, 1);
      chk("midrst_donated", d0, 0);
      chk("midrst_slot_start", ss0, 1);
      chk("midrst_cycle_ready", cr0, 0);
      chk("midrst_clk8n", n0, 1);
      tick();
      chk("midrst_hold_cr", cr0, 0);
      chk("midrst_hold_phase", ph0, 0);
      reset_n = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         tick();
         reset_n = ($urandom_range(0, 299) != 0);
         req0 = 2'($urandom_range(0, 3));
         req1 = 3'($urandom_range(0, 7));
         stall0 = ($urandom_range(0, 3) == 0);
         stall1 = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) don0 = !don0;
         if ($urandom_range(0, 19) == 0) don1 = !don1;
      end
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
